// File: rtl/vga_pkg.sv
// Shared timing constants, mode encodings and helpers
// for the 800x480 panel display path.
package vga_pkg;

  localparam int H_SYNC  = 128;
  localparam int H_BACK  = 88;
  localparam int H_VALID = 800;
  localparam int H_FRONT = 40;
  localparam int H_TOTAL = H_SYNC + H_BACK
                         + H_VALID + H_FRONT;

  localparam int V_SYNC  = 2;
  localparam int V_BACK  = 33;
  localparam int V_VALID = 480;
  localparam int V_FRONT = 10;
  localparam int V_TOTAL = V_SYNC + V_BACK
                         + V_VALID + V_FRONT;

  localparam int PIX_LEAD_DEF = 2;

  localparam int CW = 11;
  typedef logic [CW-1:0] cnt_t;

  localparam logic [9:0] PIX_NONE = 10'h3FF;

  typedef enum logic [3:0] {
    MODE_IDLE = 4'b0000,
    MODE_RGB  = 4'b0001,
    MODE_GRAY = 4'b0010,
    MODE_EDGE = 4'b0100
  } mode_e;

  function automatic logic in_win(
    input cnt_t c,
    input cnt_t lo,
    input cnt_t hi
  );
    return (c >= lo) && (c < hi);
  endfunction

endpackage

// File: rtl/vga_ctrl_if.sv
// Bundle between the timing generator, the picture
// stage (pix request / colour return) and the panel.
interface vga_ctrl_if;

  logic [3:0]  keyin_raw;
  logic [23:0] color_in;
  logic [9:0]  pix_x;
  logic [9:0]  pix_y;
  logic [3:0]  keyin;
  logic        frame_start;
  logic        hsync;
  logic        vsync;
  logic        de;
  logic [23:0] rgb;

  modport master (
    input  keyin_raw,
    input  color_in,
    output pix_x,
    output pix_y,
    output keyin,
    output frame_start,
    output hsync,
    output vsync,
    output de,
    output rgb
  );

  modport slave (
    output keyin_raw,
    output color_in,
    input  pix_x,
    input  pix_y,
    input  keyin,
    input  frame_start,
    input  hsync,
    input  vsync,
    input  de,
    input  rgb
  );

endinterface

// File: rtl/vga_timing_cnt.sv
// Free-running h/v raster counters with a registered
// frame_start pulse marking each pass through (0,0).
module vga_timing_cnt
  import vga_pkg::*;
#(
  parameter int H_TOT = H_TOTAL,
  parameter int V_TOT = V_TOTAL
) (
  input  logic clk_i,
  input  logic rst_i,
  output cnt_t cnt_h_o,
  output cnt_t cnt_v_o,
  output logic frame_start_o
);

  localparam cnt_t H_LAST = cnt_t'(H_TOT - 1);
  localparam cnt_t V_LAST = cnt_t'(V_TOT - 1);

  cnt_t h_q, h_d;
  cnt_t v_q, v_d;
  logic fs_q, fs_d;
  logic h_end, v_end;

  always_comb begin
    h_end = (h_q == H_LAST);
    v_end = (v_q == V_LAST);
    h_d   = h_end ? '0 : h_q + cnt_t'(1);
    v_d   = v_q;
    if (h_end) begin
      v_d = v_end ? '0 : v_q + cnt_t'(1);
    end
    // pulse follows the cycle spent at (0,0)
    fs_d = (h_q == '0) && (v_q == '0);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      h_q  <= '0;
      v_q  <= '0;
      fs_q <= 1'b0;
    end else begin
      h_q  <= h_d;
      v_q  <= v_d;
      fs_q <= fs_d;
    end
  end

  assign cnt_h_o       = h_q;
  assign cnt_v_o       = v_q;
  assign frame_start_o = fs_q;

endmodule

// File: rtl/vga_ctrl.sv
// Display timing generator and pixel output stage:
// leads pix requests, registers sync/de/rgb, latches mode.
module vga_ctrl
  import vga_pkg::*;
#(
  parameter int H_SYNC   = vga_pkg::H_SYNC,
  parameter int H_BACK   = vga_pkg::H_BACK,
  parameter int H_VALID  = vga_pkg::H_VALID,
  parameter int H_FRONT  = vga_pkg::H_FRONT,
  parameter int V_SYNC   = vga_pkg::V_SYNC,
  parameter int V_BACK   = vga_pkg::V_BACK,
  parameter int V_VALID  = vga_pkg::V_VALID,
  parameter int V_FRONT  = vga_pkg::V_FRONT,
  parameter int PIX_LEAD = PIX_LEAD_DEF
) (
  input  logic       clk,
  input  logic       rst,
  vga_ctrl_if.master vif
);

  localparam int HA  = H_SYNC + H_BACK;
  localparam int VA  = V_SYNC + V_BACK;
  localparam int HT  = HA + H_VALID + H_FRONT;
  localparam int VT  = VA + V_VALID + V_FRONT;

  localparam cnt_t HA_LO  = cnt_t'(HA);
  localparam cnt_t HA_HI  = cnt_t'(HA + H_VALID);
  localparam cnt_t HR_LO  = cnt_t'(HA - PIX_LEAD);
  localparam cnt_t HR_HI  = cnt_t'(HA + H_VALID - PIX_LEAD);
  localparam cnt_t VA_LO  = cnt_t'(VA);
  localparam cnt_t VA_HI  = cnt_t'(VA + V_VALID);
  localparam cnt_t HS_END = cnt_t'(H_SYNC);
  localparam cnt_t VS_END = cnt_t'(V_SYNC);

  cnt_t cnt_h, cnt_v;
  logic frame_start;

  vga_timing_cnt #(
    .H_TOT (HT),
    .V_TOT (VT)
  ) u_cnt (
    .clk_i         (clk),
    .rst_i         (rst),
    .cnt_h_o       (cnt_h),
    .cnt_v_o       (cnt_v),
    .frame_start_o (frame_start)
  );

  logic v_in, hs_i, vs_i, de_i, req_i;

  // request window runs PIX_LEAD clocks ahead of de
  always_comb begin
    v_in  = in_win(cnt_v, VA_LO, VA_HI);
    hs_i  = cnt_h < HS_END;
    vs_i  = cnt_v < VS_END;
    de_i  = v_in && in_win(cnt_h, HA_LO, HA_HI);
    req_i = v_in && in_win(cnt_h, HR_LO, HR_HI);
  end

  assign vif.pix_x = req_i ? 10'(cnt_h - HR_LO)
                           : PIX_NONE;
  assign vif.pix_y = req_i ? 10'(cnt_v - VA_LO)
                           : PIX_NONE;

  logic        hs_q, vs_q, de_q;
  logic [23:0] rgb_q, rgb_d;
  logic [3:0]  key_q, key_d;

  always_comb begin
    rgb_d = de_i ? vif.color_in : 24'h0;
    key_d = frame_start ? vif.keyin_raw : key_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hs_q  <= 1'b0;
      vs_q  <= 1'b0;
      de_q  <= 1'b0;
      rgb_q <= '0;
      key_q <= '0;
    end else begin
      hs_q  <= hs_i;
      vs_q  <= vs_i;
      de_q  <= de_i;
      rgb_q <= rgb_d;
      key_q <= key_d;
    end
  end

  assign vif.hsync       = hs_q;
  assign vif.vsync       = vs_q;
  assign vif.de          = de_q;
  assign vif.rgb         = rgb_q;
  assign vif.keyin       = key_q;
  assign vif.frame_start = frame_start;

endmodule
